// File: rtl/addsub_seq_if.sv
// Handshake and operand/result bundle for the multi-cycle adder/subtractor.
// With ADDSUB_SAT_EN defined, the bundle also carries the per-operation sat request.
interface addsub_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ADDSUB_SAT_EN
  logic             sat;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, sub, a, b,
`ifdef ADDSUB_SAT_EN
    output sat,
`endif
    input  busy, done, result, carry_out, overflow, zero, negative
  );

  modport slave (
    input  start, sub, a, b,
`ifdef ADDSUB_SAT_EN
    input  sat,
`endif
    output busy, done, result, carry_out, overflow, zero, negative
  );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock with
// ripple carry between chunks, start/busy/done handshake, registered flags.
// Optional feature macro: ADDSUB_SAT_EN (adds sat request; clamps on signed overflow).
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  addsub_seq_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;
  logic             negative_q;
`ifdef ADDSUB_SAT_EN
  logic             sat_q;
`endif

  logic             accept;
  logic             last;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_raw;
  logic [WIDTH-1:0] res_final;
  logic             ovf;

`ifdef ADDSUB_SAT_EN
  // Replace an overflowed result with the most positive or most negative value.
  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] r,
                                                 input logic a_msb,
                                                 input logic do_clamp);
    if (!do_clamp) return r;
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (state_q == RUN) && (idx_q == LAST_IDX);

  // Current chunk sum and the full result it produces once written back.
  always_comb begin
    chunk_sum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
              + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    res_raw = result_q;
    res_raw[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_raw[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    res_final = sat_clamp(res_raw, a_q[WIDTH-1], sat_q && ovf);
`else
    res_final = res_raw;
`endif
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last)   state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture; subtraction is folded in as A + ~B + 1.
  always_ff @(posedge clock) begin
    if (accept) begin
      a_q <= bus.a;
      b_q <= bus.sub ? ~bus.b : bus.b;
`ifdef ADDSUB_SAT_EN
      sat_q <= bus.sat;
`endif
    end
  end

  // Chunk sequencing, progressive result write-back and flag capture on the last chunk.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= bus.sub;
    end else if (state_q == RUN) begin
      idx_q    <= idx_q + 1'b1;
      carry_q  <= chunk_sum[CHUNK];
      result_q <= last ? res_final : res_raw;
      if (last) begin
        carry_out_q <= chunk_sum[CHUNK];
        overflow_q  <= ovf;
        zero_q      <= (res_final == '0);
        negative_q  <= res_final[WIDTH-1];
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;

endmodule
